// File: rtl/wr_memory_pkg.sv
// Shared definitions for the asymmetric-width FIFO memories: FSM encoding and
// the geometry check reused by the read-side memory.
package wr_memory_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Buffer size must match exactly one full set of word slots.
    function automatic bit depth_ok(input int data_width, input int addr_width,
                                    input int mem_depth);
        return mem_depth == (data_width << addr_width);
    endfunction

endpackage

// File: rtl/wr_memory.sv
// Write-side FIFO storage: packs words into a flat buffer, raises full when
// complete, and holds the snapshot one extra cycle after the read side releases it.
module wr_memory
    import wr_memory_pkg::*;
#(
    parameter int WR_DATA_WIDTH = 2,
    parameter int WR_ADDR_WIDTH = 1,
    parameter int MEM_DEPTH     = 4
) (
    input  logic                     wr_clk,
    input  logic                     reset,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     wr_en,
    input  logic                     rd_release,
    output logic [MEM_DEPTH-1:0]     remapping_memory,
    output logic                     full,
    output logic [WR_ADDR_WIDTH-1:0] wr_addr,
    output logic                     overflow
);

    if (!depth_ok(WR_DATA_WIDTH, WR_ADDR_WIDTH, MEM_DEPTH)) begin : g_bad_depth
        $error("wr_memory: MEM_DEPTH must equal WR_DATA_WIDTH * 2**WR_ADDR_WIDTH");
    end

    state_t                   state, state_n;
    logic [MEM_DEPTH-1:0]     mem_n;
    logic                     full_n;
    logic [WR_ADDR_WIDTH-1:0] addr_n;
    logic                     ovf_n;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state            <= FILL;
            remapping_memory <= '0;
            full             <= 1'b0;
            wr_addr          <= '0;
            overflow         <= 1'b0;
        end else begin
            state            <= state_n;
            remapping_memory <= mem_n;
            full             <= full_n;
            wr_addr          <= addr_n;
            overflow         <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        mem_n   = remapping_memory;
        full_n  = full;
        addr_n  = wr_addr;
        ovf_n   = 1'b0;
        case (state)
            FILL: begin
                if (wr_en) begin
                    mem_n[int'(wr_addr) * WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
                    addr_n = wr_addr + 1'b1;  // last slot is all-ones, so this wraps to 0
                    if (&wr_addr) begin
                        full_n  = 1'b1;
                        state_n = FULL;
                    end
                end
            end
            FULL: begin
                ovf_n = wr_en;
                if (rd_release) begin
                    full_n  = 1'b0;
                    addr_n  = '0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // Buffer stays frozen while the read side captures on full's falling edge.
                ovf_n   = wr_en;
                state_n = FILL;
            end
            default: state_n = FILL;
        endcase
    end

endmodule

// File: tb/tb_wr_memory.sv
// Directed self-checking bench for wr_memory: default geometry plus a 1-bit x 4 instance.
module tb_wr_memory;

    logic       wr_clk = 1'b0;
    logic       reset  = 1'b1;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [1:0] a_data = '0;
    logic       a_en = 1'b0, a_rel = 1'b0;
    logic [3:0] a_mem;
    logic       a_full, a_ovf;
    logic [0:0] a_addr;

    logic [0:0] b_data = '0;
    logic       b_en = 1'b0, b_rel = 1'b0;
    logic [3:0] b_mem;
    logic       b_full, b_ovf;
    logic [1:0] b_addr;

    always #5 wr_clk = ~wr_clk;

    wr_memory #(.WR_DATA_WIDTH(2), .WR_ADDR_WIDTH(1), .MEM_DEPTH(4)) dut_a (
        .wr_clk(wr_clk), .reset(reset), .wr_data(a_data), .wr_en(a_en),
        .rd_release(a_rel), .remapping_memory(a_mem), .full(a_full),
        .wr_addr(a_addr), .overflow(a_ovf)
    );

    wr_memory #(.WR_DATA_WIDTH(1), .WR_ADDR_WIDTH(2), .MEM_DEPTH(4)) dut_b (
        .wr_clk(wr_clk), .reset(reset), .wr_data(b_data), .wr_en(b_en),
        .rd_release(b_rel), .remapping_memory(b_mem), .full(b_full),
        .wr_addr(b_addr), .overflow(b_ovf)
    );

    task automatic cyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (a_mem !== 4'b0000) begin n_fail++; $display("FAIL reset_mem got %b want 0000", a_mem); end
        n_checks++; if ({a_full, a_addr, a_ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {a_full, a_addr, a_ovf}); end
        n_checks++; if ({b_mem, b_full, b_addr, b_ovf} !== 8'h00) begin n_fail++; $display("FAIL reset_b got %h want 00", {b_mem, b_full, b_addr, b_ovf}); end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_fill();
        a_en = 1'b1; a_data = 2'b10;
        cyc();
        n_checks++; if ({a_mem, a_full, a_addr} !== {4'b0010, 1'b0, 1'b1}) begin n_fail++; $display("FAIL fill_first got %b/%b/%b want 0010/0/1", a_mem, a_full, a_addr); end
        a_data = 2'b01;
        cyc();
        a_en = 1'b0;
        n_checks++; if (a_mem !== 4'b0110) begin n_fail++; $display("FAIL fill_mem got %b want 0110", a_mem); end
        n_checks++; if ({a_full, a_addr, a_ovf} !== 3'b100) begin n_fail++; $display("FAIL fill_flags got %b want 100", {a_full, a_addr, a_ovf}); end
    endtask

    task automatic test_overflow();
        a_en = 1'b1; a_data = 2'b11;
        cyc();
        n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_1 got %b want 1", a_ovf); end
        cyc();
        a_en = 1'b0;
        n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_2 got %b want 1", a_ovf); end
        cyc();
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", a_ovf); end
        n_checks++; if ({a_mem, a_full} !== 5'b01101) begin n_fail++; $display("FAIL ovf_keep got %b want 01101", {a_mem, a_full}); end
    endtask

    task automatic test_release_hold();
        a_rel = 1'b1;
        cyc();
        a_rel = 1'b0;
        n_checks++; if ({a_full, a_mem} !== 5'b00110) begin n_fail++; $display("FAIL hold_enter got %b want 00110", {a_full, a_mem}); end
        a_en = 1'b1; a_data = 2'b11;
        cyc();
        n_checks++; if ({a_ovf, a_mem, a_addr} !== 6'b101100) begin n_fail++; $display("FAIL hold_reject got %b want 101100", {a_ovf, a_mem, a_addr}); end
        cyc();
        a_en = 1'b0;
        n_checks++; if ({a_mem, a_addr, a_ovf} !== 6'b011110) begin n_fail++; $display("FAIL refill got %b want 011110", {a_mem, a_addr, a_ovf}); end
    endtask

    task automatic test_simultaneous();
        a_en = 1'b1; a_data = 2'b01;
        cyc();
        a_en = 1'b0;
        n_checks++; if ({a_full, a_mem} !== 5'b10111) begin n_fail++; $display("FAIL sim_refull got %b want 10111", {a_full, a_mem}); end
        a_rel = 1'b1; a_en = 1'b1; a_data = 2'b00;
        cyc();
        a_rel = 1'b0; a_en = 1'b0;
        n_checks++; if ({a_full, a_ovf, a_mem} !== 6'b010111) begin n_fail++; $display("FAIL sim_both got %b want 010111", {a_full, a_ovf, a_mem}); end
        cyc();
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL sim_ovf_clear got %b want 0", a_ovf); end
    endtask

    task automatic test_reset_mid();
        a_en = 1'b1; a_data = 2'b10;
        cyc();
        a_en = 1'b0;
        n_checks++; if (a_addr !== 1'b1) begin n_fail++; $display("FAIL mid_addr got %b want 1", a_addr); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({a_mem, a_full, a_addr, a_ovf} !== 7'b0) begin n_fail++; $display("FAIL mid_async got %b want 0000000", {a_mem, a_full, a_addr, a_ovf}); end
        #1 reset = 1'b0;
        a_en = 1'b1; a_data = 2'b11;
        cyc();
        n_checks++; if ({a_full, a_addr} !== 2'b01) begin n_fail++; $display("FAIL mid_one got %b want 01", {a_full, a_addr}); end
        cyc();
        a_en = 1'b0;
        n_checks++; if ({a_full, a_addr, a_mem} !== 6'b101111) begin n_fail++; $display("FAIL mid_two got %b want 101111", {a_full, a_addr, a_mem}); end
    endtask

    task automatic test_alt_params();
        logic [3:0] bits;
        bits = 4'b1101;
        b_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_data = bits[i];
            cyc();
            if (i == 2) begin
                n_checks++; if ({b_full, b_addr, b_mem} !== 7'b0110101) begin n_fail++; $display("FAIL alt_third got %b want 0110101", {b_full, b_addr, b_mem}); end
            end
        end
        b_en = 1'b0;
        n_checks++; if (b_mem !== 4'b1101) begin n_fail++; $display("FAIL alt_mem got %b want 1101", b_mem); end
        n_checks++; if ({b_full, b_addr} !== 3'b100) begin n_fail++; $display("FAIL alt_flags got %b want 100", {b_full, b_addr}); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release_hold();
        test_simultaneous();
        test_reset_mid();
        test_alt_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
